// File: rtl/gfx_pkg.sv
// Shared definitions for the pixel write path: Kbus field layout, FSM
// state encoding and default framebuffer geometry.
package gfx_pkg;

  localparam int KBUS_W  = 24;
  localparam int X_MSB   = 23;
  localparam int X_LSB   = 16;
  localparam int Y_MSB   = 15;
  localparam int Y_LSB   = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  localparam int DEF_FB_WIDTH  = 160;
  localparam int DEF_FB_HEIGHT = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_REQ  = 2'd2
  } pw_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for pixel commands. The head entry is visible on
// dout whenever the FIFO is non-empty; pop advances to the next entry.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] entries [DEPTH];

  // Full/empty come from occupancy before this cycle's pop, so a push
  // into a full FIFO is refused even if the head leaves on the same edge.
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = entries[rd_ptr_q];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
        entry_q <= din;
      end
    end

    assign entries[gi] = entry_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Takes DPU pixel commands, clips off-screen ones, and writes on-screen
// pixels to the framebuffer over a req/ack handshake.
module pixel_writer
  import gfx_pkg::*;
#(
  parameter int FB_WIDTH   = DEF_FB_WIDTH,
  parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KBUS_W-1:0] kbus,
  input  logic              out_enable,
  output logic              busy,
  output logic              fb_req,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  input  logic              fb_ack,
  output logic              overflow,
  output logic [15:0]       pix_written,
  output logic [15:0]       pix_clipped
);

  pw_state_e         state_q, state_d;
  logic [KBUS_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_data_q, fb_data_d;
  logic              fb_req_q, fb_req_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       pix_written_q, pix_written_d;
  logic [15:0]       pix_clipped_q, pix_clipped_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [KBUS_W-1:0] fifo_dout;

  logic [7:0]        hold_x;
  logic [7:0]        hold_y;
  logic [7:0]        hold_col;
  logic              off_screen;
  logic [ADDR_W-1:0] lin_addr;

  pixel_fifo #(
    .WIDTH (KBUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_enable),
    .din   (kbus),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign hold_x     = hold_q[X_MSB:X_LSB];
  assign hold_y     = hold_q[Y_MSB:Y_LSB];
  assign hold_col   = hold_q[COL_MSB:COL_LSB];
  assign off_screen = (32'(hold_x) >= FB_WIDTH) || (32'(hold_y) >= FB_HEIGHT);
  assign lin_addr   = ADDR_W'(hold_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(hold_x);

  assign overflow_d = overflow_q || (out_enable && fifo_full);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    fb_req_d      = fb_req_q;
    pix_written_d = pix_written_q;
    pix_clipped_d = pix_clipped_q;

    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          hold_d  = fifo_dout;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (off_screen) begin
          if (pix_clipped_q != 16'hFFFF) begin
            pix_clipped_d = pix_clipped_q + 16'd1;
          end
          state_d = ST_IDLE;
        end else begin
          fb_addr_d = lin_addr;
          fb_data_d = hold_col;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // fb_req rises one cycle after entering REQ, so address and data
        // have been stable for a full cycle before the request is seen.
        if (!fb_req_q) begin
          fb_req_d = 1'b1;
        end else if (fb_ack) begin
          fb_req_d = 1'b0;
          if (pix_written_q != 16'hFFFF) begin
            pix_written_d = pix_written_q + 16'd1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        fb_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      fb_req_q      <= 1'b0;
      overflow_q    <= 1'b0;
      pix_written_q <= '0;
      pix_clipped_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      fb_req_q      <= fb_req_d;
      overflow_q    <= overflow_d;
      pix_written_q <= pix_written_d;
      pix_clipped_q <= pix_clipped_d;
    end
  end

  assign busy        = fifo_full;
  assign fb_req      = fb_req_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign overflow    = overflow_q;
  assign pix_written = pix_written_q;
  assign pix_clipped = pix_clipped_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer at default geometry.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] kbus = '0;
  logic        out_enable = 1'b0;
  logic        busy;
  logic        fb_req;
  logic [14:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ack = 1'b0;
  logic        overflow;
  logic [15:0] pix_written;
  logic [15:0] pix_clipped;

  int n_total = 0;
  int n_pass  = 0;

  pixel_writer dut (
    .clk         (clk),
    .rst         (rst),
    .kbus        (kbus),
    .out_enable  (out_enable),
    .busy        (busy),
    .fb_req      (fb_req),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_ack      (fb_ack),
    .overflow    (overflow),
    .pix_written (pix_written),
    .pix_clipped (pix_clipped)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Called on a falling edge; the push happens on the next rising edge.
  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    kbus       = {x, y, c};
    out_enable = 1'b1;
    @(negedge clk);
    out_enable = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !fb_req; i++) @(negedge clk);
    check_eq(tag, 32'(fb_req), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  j;
    logic seen;
    logic stable;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(fb_req), 32'd0);
    check_eq("rst_addr", 32'(fb_addr), 32'd0);
    check_eq("rst_data", 32'(fb_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_written", 32'(pix_written), 32'd0);
    check_eq("rst_clipped", 32'(pix_clipped), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pixel: request rises three cycles after the push edge
    fb_ack = 1'b1;
    push(8'h05, 8'h03, 8'hAA);
    check_eq("lat_n0", 32'(fb_req), 32'd0);
    @(negedge clk);
    check_eq("lat_n1", 32'(fb_req), 32'd0);
    @(negedge clk);
    check_eq("lat_n2", 32'(fb_req), 32'd0);
    @(negedge clk);
    check_eq("lat_n3", 32'(fb_req), 32'd1);
    check_eq("single_addr", 32'(fb_addr), 32'd485);
    check_eq("single_data", 32'(fb_data), 32'hAA);
    @(negedge clk);
    check_eq("single_req_drop", 32'(fb_req), 32'd0);
    check_eq("single_written", 32'(pix_written), 32'd1);

    // Clipping at both edges of the screen, then the last legal pixel
    push(8'd160, 8'd0, 8'h11);
    push(8'd0, 8'd120, 8'h22);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (fb_req) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("clip_no_req", 32'(seen), 32'd0);
    check_eq("clip_count", 32'(pix_clipped), 32'd2);
    push(8'd159, 8'd119, 8'h33);
    wait_req("last_req");
    check_eq("last_addr", 32'(fb_addr), 32'd19199);
    check_eq("last_data", 32'(fb_data), 32'h33);
    @(negedge clk);
    check_eq("last_written", 32'(pix_written), 32'd2);

    // Overflow: six back-to-back pushes with the framebuffer stalled
    fb_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      kbus       = {8'(i * 10 + 1), 8'(i + 1), 8'(8'h40 + i)};
      out_enable = 1'b1;
      @(negedge clk);
    end
    out_enable = 1'b0;
    check_eq("ovf_busy", 32'(busy), 32'd1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_req_held", 32'(fb_req), 32'd1);
    check_eq("ovf_head_addr", 32'(fb_addr), 32'd161);
    fb_ack = 1'b1;
    j = 0;
    for (int k = 0; k < 40; k++) begin
      if (fb_req) begin
        if (j < 5) begin
          check_eq($sformatf("drain%0d_addr", j), 32'(fb_addr), 32'((j + 1) * 160 + j * 10 + 1));
          check_eq($sformatf("drain%0d_data", j), 32'(fb_data), 32'(8'h40 + j));
        end
        j++;
      end
      @(negedge clk);
    end
    check_eq("drain_count", 32'(j), 32'd5);
    check_eq("drain_written", 32'(pix_written), 32'd7);
    check_eq("drain_busy", 32'(busy), 32'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Ack stall: request, address and data hold for seven cycles
    fb_ack = 1'b0;
    push(8'd7, 8'd9, 8'h5C);
    wait_req("stall_req");
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (fb_req !== 1'b1 || fb_addr !== 15'd1447 || fb_data !== 8'h5C) stable = 1'b0;
      @(negedge clk);
    end
    check_eq("stall_stable", 32'(stable), 32'd1);
    check_eq("stall_no_write", 32'(pix_written), 32'd7);
    fb_ack = 1'b1;
    @(negedge clk);
    check_eq("stall_written", 32'(pix_written), 32'd8);
    check_eq("stall_req_drop", 32'(fb_req), 32'd0);
    idle_cycles(4);
    check_eq("spurious_ack", 32'(pix_written), 32'd8);

    // Reset while a request is outstanding and acked on the same edge
    fb_ack = 1'b0;
    push(8'd2, 8'd2, 8'h77);
    push(8'd3, 8'd3, 8'h78);
    wait_req("mid_req");
    fb_ack = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    fb_ack = 1'b0;
    check_eq("mid_rst_req", 32'(fb_req), 32'd0);
    check_eq("mid_rst_written", 32'(pix_written), 32'd0);
    check_eq("mid_rst_clipped", 32'(pix_clipped), 32'd0);
    check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fb_req) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("mid_rst_fifo_empty", 32'(seen), 32'd0);

    // Saturation of both counters
    force dut.pix_written_q = 16'hFFFE;
    force dut.pix_clipped_q = 16'hFFFF;
    #1;
    release dut.pix_written_q;
    release dut.pix_clipped_q;
    @(negedge clk);
    fb_ack = 1'b1;
    push(8'd1, 8'd1, 8'h01);
    idle_cycles(6);
    check_eq("sat_reach", 32'(pix_written), 32'hFFFF);
    push(8'd1, 8'd2, 8'h02);
    idle_cycles(6);
    check_eq("sat_written_hold", 32'(pix_written), 32'hFFFF);
    push(8'd255, 8'd0, 8'h03);
    idle_cycles(6);
    check_eq("sat_clipped_hold", 32'(pix_clipped), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
